// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
// -----------------------------------------------------------------------------
// APB completer holding DEPTH 32-bit registers. Every transfer gets
// WAIT_CYCLES wait states before pready. Misaligned and out-of-range accesses
// are decoded as invalid. An invalid write is dropped, and an invalid read
// returns zero.
//
// Optional feature macro: APB_SLAVE_REGFILE_ERR_EN
//   defined   -> invalid accesses complete with pslverr=1
//   undefined -> pslverr is tied low (invalid accesses still dropped / read 0)
//
// Parameters:
//   DEPTH       number of 32-bit registers, power of two, 2..256
//   WAIT_CYCLES wait states before pready, 0..15
//
// Ports:
//   pclk     in   clock, all state changes on the rising edge
//   prst     in   synchronous active-high reset
//   psel     in   slave select
//   penable  in   access-phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   [31:0] byte address
//   pwdata   in   [31:0] write data (sampled in the setup phase only)
//   prdata   out  [31:0] read data, valid while pready=1 on a read
//   pready   out  transfer-complete handshake (registered)
//   pslverr  out  error response, valid only while pready=1
// -----------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // An access is invalid when it is not word aligned or lies past the last register.
  function automatic logic addr_invalid(input logic [31:0] addr);
    addr_invalid = (addr[1:0] != 2'b00) || (addr >= ADDR_LIMIT);
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [3:0]         cnt_r;
  logic [31:0]        addr_r;
  logic               write_r;
  logic [31:0]        wdata_r;
  logic [31:0]        regs_r [DEPTH];
  logic [31:0]        prdata_r;
  logic               pready_r;

  logic               setup_s;
  logic               access_s;
  logic [31:0]        dec_addr_s;
  logic               dec_write_s;
  logic               dec_invalid_s;
  logic [IDX_W-1:0]   dec_idx_s;
  logic [31:0]        rd_data_s;
  logic               enter_done_s;
  logic               commit_s;

  assign setup_s  = psel & ~penable;
  assign access_s = psel & penable;

  // Next-state logic. Losing psel/penable while waiting aborts the transfer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (setup_s) begin
          if (WAIT_INIT == 4'd0) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!access_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == 4'd1) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Decode of the transfer heading for DONE. With zero wait states DONE is
  // entered straight from the setup edge, before the latches hold the address.
  // In that case the live bus is decoded instead.
  always_comb begin
    dec_addr_s  = addr_r;
    dec_write_s = write_r;
    if (state_r == ST_IDLE) begin
      dec_addr_s  = paddr;
      dec_write_s = pwrite;
    end else begin
      dec_addr_s  = addr_r;
      dec_write_s = write_r;
    end
    dec_invalid_s = addr_invalid(dec_addr_s);
    dec_idx_s     = dec_addr_s[2 +: IDX_W];
    if (dec_write_s || dec_invalid_s) begin
      rd_data_s = 32'h0000_0000;
    end else begin
      rd_data_s = regs_r[dec_idx_s];
    end
  end

  assign enter_done_s = (state_nxt_s == ST_DONE) && (state_r != ST_DONE);
  assign commit_s     = (state_r == ST_DONE) && access_s && write_r && !addr_invalid(addr_r);

  // Control state. This block holds the FSM, the wait counter, the setup-phase
  // latches and the registered response.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= 32'h0000_0000;
      write_r  <= 1'b0;
      wdata_r  <= 32'h0000_0000;
      prdata_r <= 32'h0000_0000;
      pready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_IDLE) && setup_s) begin
        addr_r  <= paddr;
        write_r <= pwrite;
        wdata_r <= pwdata;
        cnt_r   <= WAIT_INIT;
      end else if (state_r == ST_WAIT) begin
        if (access_s) begin
          cnt_r <= cnt_r - 4'd1;
        end else begin
          cnt_r <= 4'd0;
        end
      end else begin
        cnt_r <= cnt_r;
      end
      // The response is held only for the single DONE cycle.
      if (enter_done_s) begin
        pready_r <= 1'b1;
        prdata_r <= rd_data_s;
      end else begin
        pready_r <= 1'b0;
        prdata_r <= 32'h0000_0000;
      end
    end
  end

  // Register file. A write lands on the completion edge, and reset clears every entry.
  always_ff @(posedge pclk) begin
    if (prst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if (commit_s) begin
      regs_r[addr_r[2 +: IDX_W]] <= wdata_r;
    end else begin
      regs_r <= regs_r;
    end
  end

`ifdef APB_SLAVE_REGFILE_ERR_EN
  logic pslverr_r;

  // Error response, loaded together with pready on entry to DONE.
  always_ff @(posedge pclk) begin
    if (prst) begin
      pslverr_r <= 1'b0;
    end else if (enter_done_s) begin
      pslverr_r <= dec_invalid_s;
    end else begin
      pslverr_r <= 1'b0;
    end
  end

  assign pslverr = pslverr_r;
`else
  assign pslverr = 1'b0;
`endif

  assign prdata = prdata_r;
  assign pready = pready_r;

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer that terminates the transfers issued by the team's APB master: it samples `psel`/`penable`/`pwrite`/`paddr`/`pwdata` and returns `prdata`/`pready`/`pslverr`. It holds a DEPTH-word register file, inserts a programmable number of wait states via `pready`, and flags misaligned or out-of-range accesses. It sits directly downstream of the master on the APB bus.

## Interface
- Reset: one clock; reset is synchronous and active-high.
- Parameters:
  - `DEPTH`, default 16: number of 32-bit registers; must be a power of two, 2..256.
  - `WAIT_CYCLES`, default 1: wait states inserted before `pready`; range 0..15.
- Ports:
  - `pclk`, in, 1: clock; all state changes on its rising edge.
  - `prst`, in, 1: synchronous active-high reset.
  - `psel`, in, 1: slave select.
  - `penable`, in, 1: access-phase indicator.
  - `pwrite`, in, 1: 1 = write, 0 = read.
  - `paddr`, in, 32: byte address.
  - `pwdata`, in, 32: write data.
  - `prdata`, out, 32: read data; valid while `pready`=1 on a read.
  - `pready`, out, 1: transfer-complete handshake.
  - `pslverr`, out, 1: error response; valid only while `pready`=1.

## Operation
- **Reset values** (`prst`=1 at an edge): `prdata`=0, `pready`=0, `pslverr`=0, state=IDLE, wait counter=0, all registers=0. Reset overrides any transfer in flight; an aborted write does not modify the register file.
- **FSM states**: IDLE, WAIT, DONE.
- **IDLE**
  - A setup phase (`psel`=1, `penable`=0) at an edge latches `paddr`, `pwrite` and `pwdata`, and loads the counter with WAIT_CYCLES.
  - If WAIT_CYCLES=0 the next state is DONE; otherwise it is WAIT.
- **WAIT**
  - Counter decrements each edge; on the edge where it reaches 1, next state is DONE.
  - If `psel`=0 or `penable`=0 during WAIT, this is a protocol abort: return to IDLE and perform no write.
- **DONE**
  - `pready`=1 for exactly one cycle; the transfer completes on the edge where `psel`=`penable`=`pready`=1.
  - At that edge a valid write updates `reg[idx]`. `pready`, `pslverr` and `prdata` return to 0, and the state returns to IDLE.
- **Decode**
  - `idx` = `paddr[2 +: log2(DEPTH)]`.
  - An access is invalid when `paddr[1:0]`≠0 or `paddr` ≥ DEPTH×4.
- **Registered outputs**: `prdata` and `pslverr` are registered and loaded on the edge entering DONE.
  - Valid read: `prdata` = `reg[idx]`.
  - Write or invalid access: `prdata` = 0.
- **Back-to-back transfers**: a setup phase in the cycle right after DONE is accepted as a new transfer, with no idle cycle required.
- **Write-data latching**: `pwdata` is taken from the setup-phase latch. Changes on the bus during the access phase are ignored.

## Timing
- Access phase lasts WAIT_CYCLES+1 cycles. Total transfer is WAIT_CYCLES+2 cycles, counted from setup to the completion edge.
- `pready` is registered and never combinational from the inputs.
- Read data reflects register contents as they stood at the edge entering DONE. A write and a following read of the same index return the new value.
- Register file write latency: 0 cycles after the completion edge.

## Configuration
- Macro: `APB_SLAVE_REGFILE_ERR_EN`.
  - Defined: invalid accesses return `pslverr`=1 with `pready`; invalid writes are dropped; invalid reads return `prdata`=0.
  - Undefined: `pslverr` is tied to 0. Invalid writes are still dropped and invalid reads still return 0, but the error is silent.

## Test plan
- **Reset and write/readback**, WAIT_CYCLES=1, DEPTH=16: hold `prst` for 2 cycles, then write 0xDEADBEEF to 0x08 and read 0x08.
  - Required: `pready` high on the 3rd cycle of each transfer, `prdata`=0xDEADBEEF, `pslverr`=0.
- **Zero-wait back-to-back**, WAIT_CYCLES=0: write 0x11 to 0x00, then immediately read 0x00 with no idle cycle.
  - Required: each transfer is 2 cycles and the read returns 0x11.
- **Error response**, with `APB_SLAVE_REGFILE_ERR_EN`: write to 0x40 (out of range), then read 0x06 (misaligned).
  - Required: both return `pslverr`=1 and `prdata`=0; register contents are unchanged.
  - Without the macro: `pslverr`=0 on both.
- **Abort**, WAIT_CYCLES=3: write setup to 0x04 with value 0xAA, then drop `psel` during the 2nd wait cycle.
  - Required: FSM is back in IDLE, `pready` never asserts, and a later read of 0x04 returns 0.
- **Reset mid-transfer**: assert `prst` during WAIT of a write to 0x0C.
  - Required: all outputs are 0 on the next cycle and `reg[3]` is still 0.
- **Bus-change immunity**: change `pwdata` during the access phase of a write of 0x55 to 0x10.
  - Required: readback of 0x10 returns 0x55.
